cva6_lsu_issue_arb: RTL and testbench

Round-robin issue arbiter that shares one `cva6_lsu_model`/`cva6_lsu_shim` instance between `NUM_REQ` requesters. It sits in front of the LSU.
- Accepts load/store instructions from requesters.
- Issues at most one load and one store outstanding at a time.
- Holds loads that alias the outstanding store.
- Routes memory completions back to the owning requester.

---
 rtl/cva6_lsu_pkg.sv | 21 ++
 rtl/cva6_lsu_rr_arb.sv | 45 ++++
 rtl/cva6_lsu_issue_arb.sv | 137 +++++++++++++
 tb/tb_cva6_lsu_issue_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_lsu_pkg.sv
// Shared types and sizing for the LSU issue arbiter slice.
package cva6_lsu_pkg;

  // Owner index is sized for the largest supported requester count.
  localparam int unsigned MAX_REQ     = 4;
  localparam int unsigned REQ_IDX_W   = $clog2(MAX_REQ);
  localparam int unsigned LSU_INSTR_W = 32;
  localparam int unsigned LSU_ADDR_W  = 12;

  typedef struct packed {
    logic [LSU_INSTR_W-1:0] instr;
    logic                   is_load;
  } lsu_req_t;

  typedef struct packed {
    logic                  busy;
    logic [REQ_IDX_W-1:0]  owner;
    logic [LSU_ADDR_W-1:0] addr;
  } lsu_trk_t;

endpackage

// File: rtl/cva6_lsu_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr_i.
module cva6_lsu_rr_arb
  import cva6_lsu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]   eligible_i,
  input  logic [REQ_IDX_W-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [REQ_IDX_W-1:0] winner_o,
  output logic                 valid_o
);

  logic                 w_found;
  logic [REQ_IDX_W-1:0] w_win;

  // Two passes: upper segment from the pointer, then wrap to the lowest index.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && eligible_i[i] && (REQ_IDX_W'(i) >= rr_ptr_i)) begin
        w_found = 1'b1;
        w_win   = REQ_IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && eligible_i[i]) begin
        w_found = 1'b1;
        w_win   = REQ_IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_o[i] = w_found && (w_win == REQ_IDX_W'(i));
    end
  end

  assign winner_o = w_win;
  assign valid_o  = w_found;

endmodule

// File: rtl/cva6_lsu_issue_arb.sv
// Round-robin issue arbiter sharing one LSU between NUM_REQ requesters,
// with one outstanding load and one outstanding store tracked for completion routing.
module cva6_lsu_issue_arb
  import cva6_lsu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned INSTR_W = LSU_INSTR_W,
  parameter int unsigned ADDR_W  = LSU_ADDR_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr_i,
  input  logic [NUM_REQ-1:0]         req_is_load_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [INSTR_W-1:0]         lsu_instr_o,
  output logic                       lsu_is_load_o,
  output logic                       lsu_instr_valid_o,
  input  logic                       lsu_ready_i,
  input  logic                       load_mem_resp_i,
  input  logic                       store_mem_resp_i,
  output logic [NUM_REQ-1:0]         load_done_o,
  output logic [NUM_REQ-1:0]         store_done_o,
  output logic                       busy_o,
  output logic                       err_o
);

  if (INSTR_W != LSU_INSTR_W || ADDR_W != LSU_ADDR_W || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_params
    $error("cva6_lsu_issue_arb: unsupported parameter combination");
  end

  lsu_req_t             w_req [NUM_REQ];
  lsu_req_t             w_win_req;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [REQ_IDX_W-1:0] w_winner;
  logic                 w_grant_vld;
  logic                 w_ld_resp_ok;
  logic                 w_st_resp_ok;

  lsu_req_t             r_issue;
  logic                 r_issue_pending;
  logic                 r_ld_busy;
  logic [REQ_IDX_W-1:0] r_ld_owner;
  lsu_trk_t             r_st;
  logic [REQ_IDX_W-1:0] r_rr_ptr;
  logic                 r_err;

  // Eligibility is gated by rst_ni so no grant is visible while reset is held.
  always_comb begin
    w_elig = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_req[k].instr   = req_instr_i[k*INSTR_W +: INSTR_W];
      w_req[k].is_load = req_is_load_i[k];
      if (rst_ni && req_valid_i[k] && lsu_ready_i && !r_issue_pending) begin
        if (req_is_load_i[k]) begin
          w_elig[k] = !r_ld_busy &&
                      !(r_st.busy && (w_req[k].instr[ADDR_W-1:0] == r_st.addr));
        end else begin
          w_elig[k] = !r_st.busy;
        end
      end
    end
  end

  cva6_lsu_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .eligible_i (w_elig),
    .rr_ptr_i   (r_rr_ptr),
    .grant_o    (w_grant),
    .winner_o   (w_winner),
    .valid_o    (w_grant_vld)
  );

  always_comb begin
    w_win_req = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_win_req = w_req[k];
    end
  end

  assign w_ld_resp_ok = load_mem_resp_i  && r_ld_busy;
  assign w_st_resp_ok = store_mem_resp_i && r_st.busy;

  always_comb begin
    load_done_o  = '0;
    store_done_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      load_done_o[k]  = w_ld_resp_ok && (r_ld_owner == REQ_IDX_W'(k));
      store_done_o[k] = w_st_resp_ok && (r_st.owner == REQ_IDX_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue         <= '0;
      r_issue_pending <= 1'b0;
      r_ld_busy       <= 1'b0;
      r_ld_owner      <= '0;
      r_st            <= '0;
      r_rr_ptr        <= '0;
      r_err           <= 1'b0;
    end else begin
      r_issue_pending <= w_grant_vld;
      if (w_grant_vld) begin
        r_issue  <= w_win_req;
        r_rr_ptr <= (w_winner == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      // An accept can only meet a stray response on the same tracker, so set wins.
      if (w_grant_vld && w_win_req.is_load) begin
        r_ld_busy  <= 1'b1;
        r_ld_owner <= w_winner;
      end else if (w_ld_resp_ok) begin
        r_ld_busy  <= 1'b0;
      end
      if (w_grant_vld && !w_win_req.is_load) begin
        r_st.busy  <= 1'b1;
        r_st.owner <= w_winner;
        r_st.addr  <= w_win_req.instr[ADDR_W-1:0];
      end else if (w_st_resp_ok) begin
        r_st.busy  <= 1'b0;
      end
      if ((load_mem_resp_i && !r_ld_busy) || (store_mem_resp_i && !r_st.busy)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready_o       = w_grant;
  assign lsu_instr_o       = r_issue.instr;
  assign lsu_is_load_o     = r_issue.is_load;
  assign lsu_instr_valid_o = r_issue_pending;
  assign busy_o            = r_ld_busy | r_st.busy | r_issue_pending;
  assign err_o             = r_err;

endmodule

// File: tb/tb_cva6_lsu_issue_arb.sv
// Directed bench for cva6_lsu_issue_arb with two requesters.
module tb_cva6_lsu_issue_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid_i;
  logic [63:0] req_instr_i;
  logic [1:0]  req_is_load_i;
  logic [1:0]  req_ready_o;
  logic [31:0] lsu_instr_o;
  logic        lsu_is_load_o;
  logic        lsu_instr_valid_o;
  logic        lsu_ready_i;
  logic        load_mem_resp_i;
  logic        store_mem_resp_i;
  logic [1:0]  load_done_o;
  logic [1:0]  store_done_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cva6_lsu_issue_arb #(
    .NUM_REQ (2),
    .INSTR_W (32),
    .ADDR_W  (12)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_instr_i       (req_instr_i),
    .req_is_load_i     (req_is_load_i),
    .req_ready_o       (req_ready_o),
    .lsu_instr_o       (lsu_instr_o),
    .lsu_is_load_o     (lsu_is_load_o),
    .lsu_instr_valid_o (lsu_instr_valid_o),
    .lsu_ready_i       (lsu_ready_i),
    .load_mem_resp_i   (load_mem_resp_i),
    .store_mem_resp_i  (store_mem_resp_i),
    .load_done_o       (load_done_o),
    .store_done_o      (store_done_o),
    .busy_o            (busy_o),
    .err_o             (err_o)
  );

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    req_valid_i      = '0;
    req_instr_i      = '0;
    req_is_load_i    = '0;
    lsu_ready_i      = 1'b1;
    load_mem_resp_i  = 1'b0;
    store_mem_resp_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_valid_i   = 2'b11;
    req_is_load_i = 2'b01;
    #1;
    checks++;
    if ({req_ready_o, lsu_instr_o, lsu_is_load_o, lsu_instr_valid_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_issue_outs got %h exp 0", {req_ready_o, lsu_instr_o, lsu_is_load_o, lsu_instr_valid_o});
    end
    checks++;
    if ({load_done_o, store_done_o, busy_o, err_o} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status_outs got %b exp 000000", {load_done_o, store_done_o, busy_o, err_o});
    end
    do_reset();
  endtask

  task automatic test_basic_load();
    do_reset();
    req_valid_i        = 2'b01;
    req_is_load_i      = 2'b01;
    req_instr_i[31:0]  = 32'h0000_0cad;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++; $display("FAIL basic_grant got %b exp 01", req_ready_o);
    end
    tick();
    req_valid_i = 2'b00;
    #1;
    checks++;
    if ({lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o} !== {1'b1, 1'b1, 32'h0000_0cad}) begin
      errors++;
      $display("FAIL basic_issue got v=%b ld=%b i=%h exp v=1 ld=1 i=00000cad", lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_busy got %b exp 1", busy_o);
    end
    tick();
    #1;
    checks++;
    if (lsu_instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_valid_pulse got %b exp 0", lsu_instr_valid_o);
    end
    tick();
    tick();
    load_mem_resp_i = 1'b1;
    #1;
    checks++;
    if (load_done_o !== 2'b01) begin
      errors++; $display("FAIL basic_load_done got %b exp 01", load_done_o);
    end
    tick();
    load_mem_resp_i = 1'b0;
    #1;
    checks++;
    if ({load_done_o, busy_o, err_o} !== 4'b0000) begin
      errors++; $display("FAIL basic_after_done got %b exp 0000", {load_done_o, busy_o, err_o});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_oh;
    logic [31:0] exp_instr;
    do_reset();
    req_valid_i        = 2'b11;
    req_is_load_i      = 2'b00;
    req_instr_i[31:0]  = 32'h0000_0100;
    req_instr_i[63:32] = 32'h0000_0200;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_oh    = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_instr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      checks++;
      if (req_ready_o !== exp_oh) begin
        errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_ready_o, exp_oh);
      end
      tick();
      #1;
      checks++;
      if ({lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o} !== {1'b1, 1'b0, exp_instr}) begin
        errors++;
        $display("FAIL rr_issue[%0d] got v=%b ld=%b i=%h exp v=1 ld=0 i=%h", i, lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o, exp_instr);
      end
      checks++;
      if (req_ready_o !== 2'b00) begin
        errors++; $display("FAIL rr_issue_gap[%0d] got %b exp 00", i, req_ready_o);
      end
      tick();
      #1;
      checks++;
      if (req_ready_o !== 2'b00) begin
        errors++; $display("FAIL rr_store_busy[%0d] got %b exp 00", i, req_ready_o);
      end
      tick();
      store_mem_resp_i = 1'b1;
      #1;
      checks++;
      if (store_done_o !== exp_oh) begin
        errors++; $display("FAIL rr_store_done[%0d] got %b exp %b", i, store_done_o, exp_oh);
      end
      tick();
      store_mem_resp_i = 1'b0;
      #1;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_alias();
    do_reset();
    req_valid_i        = 2'b10;
    req_is_load_i      = 2'b00;
    req_instr_i[63:32] = 32'h0000_0cad;
    #1;
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++; $display("FAIL alias_store_grant got %b exp 10", req_ready_o);
    end
    tick();
    req_valid_i       = 2'b01;
    req_is_load_i     = 2'b01;
    req_instr_i[31:0] = 32'h0000_0cad;
    tick();
    #1;
    checks++;
    if (req_ready_o !== 2'b00) begin
      errors++; $display("FAIL alias_blocked_a got %b exp 00", req_ready_o);
    end
    tick();
    #1;
    checks++;
    if (req_ready_o !== 2'b00) begin
      errors++; $display("FAIL alias_blocked_b got %b exp 00", req_ready_o);
    end
    store_mem_resp_i = 1'b1;
    #1;
    checks++;
    if ({store_done_o, req_ready_o} !== 4'b1000) begin
      errors++; $display("FAIL alias_store_resp got done=%b rdy=%b exp done=10 rdy=00", store_done_o, req_ready_o);
    end
    tick();
    store_mem_resp_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++; $display("FAIL alias_release got %b exp 01", req_ready_o);
    end
    tick();
    req_valid_i = 2'b00;
    #1;
    checks++;
    if ({lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o} !== {1'b1, 1'b1, 32'h0000_0cad}) begin
      errors++; $display("FAIL alias_load_issue got v=%b ld=%b i=%h exp v=1 ld=1 i=00000cad", lsu_instr_valid_o, lsu_is_load_o, lsu_instr_o);
    end
    load_mem_resp_i = 1'b1;
    tick();
    load_mem_resp_i = 1'b0;
    // Non-aliasing load passes while the store is outstanding.
    req_valid_i        = 2'b10;
    req_is_load_i      = 2'b00;
    tick();
    req_valid_i       = 2'b01;
    req_is_load_i     = 2'b01;
    req_instr_i[31:0] = 32'h0000_0cae;
    tick();
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++; $display("FAIL alias_nonmatch_grant got %b exp 01", req_ready_o);
    end
    tick();
    req_valid_i = 2'b00;
    load_mem_resp_i  = 1'b1;
    store_mem_resp_i = 1'b1;
    tick();
    load_mem_resp_i  = 1'b0;
    store_mem_resp_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, err_o} !== 2'b00) begin
      errors++; $display("FAIL alias_cleanup got busy=%b err=%b exp 0 0", busy_o, err_o);
    end
  endtask

  task automatic test_concurrency();
    do_reset();
    req_valid_i        = 2'b11;
    req_is_load_i      = 2'b01;
    req_instr_i[31:0]  = 32'h0000_0010;
    req_instr_i[63:32] = 32'h0000_0020;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      errors++; $display("FAIL conc_load_grant got %b exp 01", req_ready_o);
    end
    tick();
    req_valid_i = 2'b10;
    #1;
    checks++;
    if (req_ready_o !== 2'b00) begin
      errors++; $display("FAIL conc_issue_gap got %b exp 00", req_ready_o);
    end
    tick();
    #1;
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++; $display("FAIL conc_store_grant got %b exp 10", req_ready_o);
    end
    tick();
    req_valid_i = 2'b00;
    tick();
    load_mem_resp_i  = 1'b1;
    store_mem_resp_i = 1'b1;
    #1;
    checks++;
    if ({load_done_o, store_done_o, busy_o} !== 5'b01101) begin
      errors++; $display("FAIL conc_both_done got ld=%b st=%b busy=%b exp 01 10 1", load_done_o, store_done_o, busy_o);
    end
    tick();
    load_mem_resp_i  = 1'b0;
    store_mem_resp_i = 1'b0;
    #1;
    checks++;
    if ({load_done_o, store_done_o, busy_o, err_o} !== 6'b000000) begin
      errors++; $display("FAIL conc_after got %b exp 000000", {load_done_o, store_done_o, busy_o, err_o});
    end
  endtask

  task automatic test_backpressure_err();
    do_reset();
    lsu_ready_i       = 1'b0;
    req_valid_i       = 2'b11;
    req_is_load_i     = 2'b01;
    req_instr_i[31:0] = 32'h0000_0abc;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({req_ready_o, busy_o} !== 3'b000) begin
        errors++; $display("FAIL bp_no_grant[%0d] got %b exp 000", i, {req_ready_o, busy_o});
      end
      tick();
    end
    req_valid_i     = 2'b00;
    lsu_ready_i     = 1'b1;
    load_mem_resp_i = 1'b1;
    #1;
    checks++;
    if ({load_done_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL stray_no_done got %b exp 000", {load_done_o, err_o});
    end
    tick();
    load_mem_resp_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL stray_err_set got %b exp 1", err_o);
    end
    repeat (3) tick();
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL stray_err_sticky got %b exp 1", err_o);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_valid_i       = 2'b01;
    req_is_load_i     = 2'b01;
    req_instr_i[31:0] = 32'h0000_0123;
    tick();
    req_valid_i = 2'b00;
    tick();
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL midop_busy got %b exp 1", busy_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, lsu_instr_o, lsu_is_load_o, lsu_instr_valid_o, load_done_o, store_done_o, busy_o, err_o} !== 42'd0) begin
      errors++;
      $display("FAIL midop_reset_outs got %h exp 0", {req_ready_o, lsu_instr_o, lsu_is_load_o, lsu_instr_valid_o, load_done_o, store_done_o, busy_o, err_o});
    end
    tick();
    rst_ni = 1'b1;
    load_mem_resp_i = 1'b1;
    #1;
    checks++;
    if (load_done_o !== 2'b00) begin
      errors++; $display("FAIL midop_no_done got %b exp 00", load_done_o);
    end
    tick();
    load_mem_resp_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL midop_err got %b exp 1", err_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_basic_load();
    test_round_robin();
    test_alias();
    test_concurrency();
    test_backpressure_err();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
